gf2m_digit_mult: RTL

Parametrised digit-serial, LSB-first interleaved multiplier computing Z = A·B mod f(x) in GF(2^M), with an optional squaring mode. It processes D bits of B per clock, so one product takes ceil(M/D) compute cycles. It is the generalised successor to the bit-serial GF(2^163) multiplier and is the field-multiply engine used by the point-arithmetic controllers. A start/busy/done handshake replaces the level-held start of the earlier block.

---
 rtl/gf2m_digit_mult.sv | 88 ++++++++
 1 files changed

// File: rtl/gf2m_digit_mult.sv
// Digit-serial LSB-first interleaved GF(2^M) multiplier, Z = A*B mod f(x),
// with optional squaring; processes D bits of B per clock over ceil(M/D) cycles.
module gf2m_digit_mult #(
    parameter int          M = 163,
    parameter logic [M-1:0] F = M'(163'hC9),
    parameter int          D = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sqr,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic [M-1:0] z,
    output logic         busy,
    output logic         done
);

    localparam int N  = (M + D - 1) / D;
    localparam int CW = $clog2(N + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t          state_q;
    logic [M-1:0]    a_q, b_q, c_q, z_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q, done_q;
    logic [M-1:0]    a_d, c_d;

    // D unrolled steps: accumulate A_j under bit j of B, then A_{j+1} = A_j*x mod f.
    always_comb begin
        a_d = a_q;
        c_d = c_q;
        for (int unsigned j = 0; j < D; j++) begin
            if (b_q[j]) begin
                c_d = c_d ^ a_d;
            end
            a_d = a_d[M-1] ? ((a_d << 1) ^ F) : (a_d << 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
            z_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= sqr ? a : b;
                        c_q     <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_d;
                    b_q   <= b_q >> D;
                    c_q   <= c_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        z_q     <= c_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign z    = z_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
